// File: rtl/scaler_tick_gen.sv
// Programmable base tick with a cascade of decimated ticks, all single-cycle strobes in the clk_i domain.
// Latency: a terminal count registers onto tick_o one cycle later. There is no backpressure: en_i holds all counters.
module scaler_tick_gen #(
    parameter int          CNT_WIDTH   = 16,
    parameter int unsigned DEFAULT_DIV = 33333,
    parameter int          NUM_STAGES  = 2,
    parameter int          STAGE_RATIO = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] div_i,
    input  logic                 div_load_i,
    input  logic                 sync_i,
    output logic [NUM_STAGES:0]  tick_o,
    output logic [CNT_WIDTH-1:0] div_o,
    output logic                 pending_o
);

    localparam int                   SW       = $clog2(STAGE_RATIO);
    localparam logic [SW-1:0]        LAST     = SW'(STAGE_RATIO - 1);
    localparam logic [CNT_WIDTH-1:0] DIV_INIT = CNT_WIDTH'(DEFAULT_DIV);

    logic [CNT_WIDTH-1:0]            presc_q, presc_d;
    logic [CNT_WIDTH-1:0]            div_q, div_d;
    logic [CNT_WIDTH-1:0]            shadow_q, shadow_d;
    logic                            pending_q, pending_d;
    logic [NUM_STAGES-1:0][SW-1:0]   stage_q, stage_d;
    logic [NUM_STAGES:0]             tick_q, tick_d;
    logic [NUM_STAGES:0]             evt;

    // evt[k] is the terminal event Tk; stage k's counter lives at stage_q[k-1].
    always_comb begin
        evt    = '0;
        evt[0] = en_i && (presc_q == div_q);
        for (int k = 1; k <= NUM_STAGES; k++) begin
            evt[k] = evt[k-1] && (stage_q[k-1] == LAST);
        end
    end

    always_comb begin
        presc_d   = presc_q;
        stage_d   = stage_q;
        tick_d    = '0;
        div_d     = div_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (sync_i) begin
            presc_d   = '0;
            stage_d   = '0;
            pending_d = 1'b0;
            if (div_load_i) begin
                shadow_d = div_i;
                div_d    = div_i;
            end else if (pending_q) begin
                div_d = shadow_q;
            end
        end else begin
            tick_d = evt;
            if (en_i) begin
                presc_d = evt[0] ? '0 : presc_q + CNT_WIDTH'(1);
            end
            for (int k = 1; k <= NUM_STAGES; k++) begin
                if (evt[k]) begin
                    stage_d[k-1] = '0;
                end else if (evt[k-1]) begin
                    stage_d[k-1] = stage_q[k-1] + SW'(1);
                end
            end
            // A pending divisor lands at T0 before any same-cycle load is considered,
            // so a load coinciding with T0 waits for the following T0.
            if (evt[0] && pending_q) begin
                div_d     = shadow_q;
                pending_d = 1'b0;
            end
            if (div_load_i) begin
                shadow_d = div_i;
                if (!en_i) begin
                    div_d     = div_i;
                    pending_d = 1'b0;
                end else begin
                    pending_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            presc_q   <= '0;
            stage_q   <= '0;
            tick_q    <= '0;
            div_q     <= DIV_INIT;
            shadow_q  <= DIV_INIT;
            pending_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            stage_q   <= stage_d;
            tick_q    <= tick_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

    assign tick_o    = tick_q;
    assign div_o     = div_q;
    assign pending_o = pending_q;

endmodule
